// File: rtl/axi_bridge_pkg.sv
// Shared encodings for the cache-to-AXI3 bridge.
package axi_bridge_pkg;

    // Request type encodings used on rd_type / wr_type.
    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    // AXI3 constants.
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;

    typedef enum logic {AR_IDLE, AR_VALID} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    // Number of byte-offset bits within a cache line.
    function automatic int unsigned line_off_w(input int unsigned line_words);
        return $clog2(4 * line_words);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: highest priority starts at ptr, one-hot grant out.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Scan requests starting at ptr and grant the first one found.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_cache_bridge.sv
// Bridge from CPU cache refill/writeback ports to one AXI3 master.
module axi_cache_bridge
    import axi_bridge_pkg::*;
#(
    parameter int unsigned NRD        = 2,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ID_W       = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    // cache read ports
    input  logic [NRD-1:0]          rd_req,
    output logic [NRD-1:0]          rd_rdy,
    input  logic [3*NRD-1:0]        rd_type,
    input  logic [32*NRD-1:0]       rd_addr,
    output logic [NRD-1:0]          ret_valid,
    output logic                    ret_last,
    output logic [31:0]             ret_data,
    // cache write port
    input  logic                    wr_req,
    output logic                    wr_rdy,
    input  logic [2:0]              wr_type,
    input  logic [31:0]             wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    // AXI3 AR
    output logic [ID_W-1:0]         arid,
    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    // AXI3 R
    input  logic [ID_W-1:0]         rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    // AXI3 AW
    output logic [ID_W-1:0]         awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    // AXI3 W
    output logic [ID_W-1:0]         wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    // AXI3 B
    input  logic [ID_W-1:0]         bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int unsigned LINE_OFF_W = line_off_w(LINE_WORDS);
    localparam int unsigned LINE_AW    = 32 - LINE_OFF_W;
    localparam int unsigned CNT_W      = $clog2(LINE_WORDS);
    localparam int unsigned PTR_W      = (NRD > 1) ? $clog2(NRD) : 1;

    ar_state_t ar_state, ar_next;
    w_state_t  w_state, w_next;

    logic [NRD-1:0]   busy, hazard, eligible, grant;
    logic [PTR_W-1:0] rr_ptr, grant_idx;
    logic [31:0]      sel_addr;
    logic [2:0]       sel_type;
    logic             ar_accept, wr_accept;
    logic             aw_done, w_done, aw_hs, w_hs;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      wbuf [LINE_WORDS];
    logic             unused_resp;

    assign unused_resp = ^{rresp, bresp, bid};

    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign awid    = ID_W'(NRD - 1);
    assign wid     = ID_W'(NRD - 1);

    // Read ports stalled by an in-flight or same-cycle write to the same line.
    always_comb begin
        hazard = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            hazard[i] = ((w_state != W_IDLE) &&
                         (rd_addr[32*i + LINE_OFF_W +: LINE_AW] == awaddr[31:LINE_OFF_W])) ||
                        (wr_accept &&
                         (rd_addr[32*i + LINE_OFF_W +: LINE_AW] == wr_addr[31:LINE_OFF_W]));
        end
        eligible = rd_req & ~busy & ~hazard;
    end

    rr_arbiter #(.N(NRD), .PTR_W(PTR_W)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Decode the winning port's index, address and type.
    always_comb begin
        grant_idx = '0;
        sel_addr  = '0;
        sel_type  = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                sel_addr  = rd_addr[32*i +: 32];
                sel_type  = rd_type[3*i +: 3];
            end
        end
    end

    // AR FSM next state, read accept and R routing.
    always_comb begin
        ar_next   = ar_state;
        rd_rdy    = '0;
        ar_accept = 1'b0;
        arvalid   = 1'b0;
        if (!areset) begin
            case (ar_state)
                AR_IDLE: if (|grant) begin
                    rd_rdy    = grant;
                    ar_accept = 1'b1;
                    ar_next   = AR_VALID;
                end
                AR_VALID: begin
                    arvalid = 1'b1;
                    if (arready) ar_next = AR_IDLE;
                end
                default: ar_next = AR_IDLE;
            endcase
        end
        rready = ~areset;
        for (int unsigned i = 0; i < NRD; i++) begin
            ret_valid[i] = rvalid & (rid == ID_W'(i)) & busy[i] & ~areset;
        end
        ret_data = rdata;
        ret_last = rlast;
    end

    // AR state, latched request fields and round-robin pointer.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ar_state <= AR_IDLE;
            arid     <= '0;
            araddr   <= '0;
            arlen    <= '0;
            arsize   <= '0;
            rr_ptr   <= '0;
        end else begin
            ar_state <= ar_next;
            if (ar_accept) begin
                arid   <= ID_W'(grant_idx);
                araddr <= sel_addr;
                arlen  <= (sel_type == TYPE_LINE) ? 4'(LINE_WORDS - 1) : 4'd0;
                arsize <= (sel_type == TYPE_LINE) ? SIZE_WORD : {1'b0, sel_type[1:0]};
                rr_ptr <= (32'(grant_idx) == NRD - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Per-port outstanding flag: set on accept, cleared by that port's rlast.
    always_ff @(posedge aclk) begin
        if (areset) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NRD; i++) begin
                if (rvalid && rlast && (rid == ID_W'(i))) busy[i] <= 1'b0;
                if (ar_accept && grant[i]) busy[i] <= 1'b1;
            end
        end
    end

    // Write FSM next state and AW/W/B handshake outputs.
    always_comb begin
        w_next    = w_state;
        wr_rdy    = (w_state == W_IDLE) & ~areset;
        awvalid   = (w_state == W_SEND) & ~aw_done & ~areset;
        wvalid    = (w_state == W_SEND) & ~w_done & ~areset;
        bready    = (w_state == W_RESP) & ~areset;
        wdata     = wbuf[cnt];
        wlast     = (4'(cnt) == awlen);
        wr_accept = wr_req & wr_rdy;
        aw_hs     = awvalid & awready;
        w_hs      = wvalid & wready;
        case (w_state)
            W_IDLE: if (wr_accept) w_next = W_SEND;
            W_SEND: if ((aw_done | aw_hs) & (w_done | (w_hs & wlast))) w_next = W_RESP;
            W_RESP: if (bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write state, AW fields, beat counter and channel-done flags.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            wstrb   <= '0;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (wr_accept) begin
                awaddr  <= wr_addr;
                awlen   <= (wr_type == TYPE_LINE) ? 4'(LINE_WORDS - 1) : 4'd0;
                awsize  <= (wr_type == TYPE_LINE) ? SIZE_WORD : {1'b0, wr_type[1:0]};
                wstrb   <= (wr_type == TYPE_LINE) ? 4'hf : wr_wstrb;
                cnt     <= '0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                // Counter holds on the last beat so it never wraps within a burst.
                if (w_hs) begin
                    if (wlast) w_done <= 1'b1;
                    else       cnt    <= cnt + 1'b1;
                end
            end
        end
    end

    // Line buffer capture on write accept.
    always_ff @(posedge aclk) begin
        if (wr_accept) begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                wbuf[k] <= wr_data[32*k +: 32];
            end
        end
    end

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed bench for axi_cache_bridge (NRD=2, LINE_WORDS=4, ID_W=4).
module tb_axi_cache_bridge;

    logic         aclk = 1'b0;
    logic         areset;
    logic [1:0]   rd_req, rd_rdy, ret_valid;
    logic [5:0]   rd_type;
    logic [63:0]  rd_addr;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req, wr_rdy;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic [3:0]   arid, arlen, arcache;
    logic [31:0]  araddr;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst, arlock;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic [3:0]   awid, awlen, awcache;
    logic [31:0]  awaddr;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst, awlock;
    logic         awvalid, awready;
    logic [3:0]   wid, wstrb;
    logic [31:0]  wdata;
    logic         wlast, wvalid, wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    int vectors    = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    axi_cache_bridge #(.NRD(2), .LINE_WORDS(4), .ID_W(4)) dut (
        .aclk(aclk), .areset(areset),
        .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_type(rd_type), .rd_addr(rd_addr),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_rdy(wr_rdy), .wr_type(wr_type), .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic clear_inputs();
        rd_req = '0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        bid = '0; bresp = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset = 1'b1;
        @(posedge aclk); @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        areset  = 1'b1;
        rd_req  = 2'b11;
        rd_type = 6'b100_100;
        wr_req  = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        vectors++; if (rd_rdy !== 2'b00) begin miscompares++; $display("FAIL reset_rd_rdy got=%b exp=00", rd_rdy); end
        vectors++; if (wr_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_wr_rdy got=%b exp=0", wr_rdy); end
        vectors++; if ({arvalid, awvalid, wvalid, bready, rready} !== 5'b0) begin miscompares++; $display("FAIL reset_valids got=%b exp=00000", {arvalid, awvalid, wvalid, bready, rready}); end
        vectors++; if (araddr !== 32'h0 || awaddr !== 32'h0 || arlen !== 4'h0) begin miscompares++; $display("FAIL reset_fields araddr=%h awaddr=%h arlen=%h exp=0", araddr, awaddr, arlen); end
        vectors++; if (arburst !== 2'b01 || awburst !== 2'b01) begin miscompares++; $display("FAIL reset_burst ar=%b aw=%b exp=01", arburst, awburst); end
        @(posedge aclk); #1;
        areset = 1'b0;
        rd_req = '0;
        wr_req = 1'b0;
    endtask

    task automatic test_line_read();
        rd_req = 2'b01; rd_type[2:0] = 3'b100; rd_addr[31:0] = 32'h1C00_0000;
        @(negedge aclk);
        vectors++; if (rd_rdy !== 2'b01) begin miscompares++; $display("FAIL line_rd_rdy got=%b exp=01", rd_rdy); end
        @(posedge aclk); #1;
        rd_req = 2'b00; arready = 1'b1;
        @(negedge aclk);
        vectors++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1C00_0000) begin miscompares++; $display("FAIL line_ar got v=%b id=%h a=%h exp 1/0/1c000000", arvalid, arid, araddr); end
        vectors++; if (arlen !== 4'd3 || arsize !== 3'd2) begin miscompares++; $display("FAIL line_arlen got len=%0d size=%0d exp 3/2", arlen, arsize); end
        @(posedge aclk); #1;
        arready = 1'b0;
        @(negedge aclk);
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL line_ar_drop got=%b exp=0", arvalid); end
        for (int k = 0; k < 4; k++) begin
            @(posedge aclk); #1;
            rvalid = 1'b1; rid = 4'd0; rdata = 32'hA000_0000 + 32'(k); rlast = (k == 3);
            @(negedge aclk);
            vectors++; if (ret_valid !== 2'b01 || ret_data !== 32'hA000_0000 + 32'(k) || ret_last !== (k == 3))
                begin miscompares++; $display("FAIL line_beat%0d got v=%b d=%h l=%b", k, ret_valid, ret_data, ret_last); end
        end
        @(posedge aclk); #1;
        rdata = 32'hDEAD_BEEF;
        @(negedge aclk);
        vectors++; if (ret_valid !== 2'b00) begin miscompares++; $display("FAIL line_busy_clear got=%b exp=00", ret_valid); end
        @(posedge aclk); #1;
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_round_robin();
        int         rr_rid [9];
        logic       rr_last[9];
        logic [1:0] rr_exp [9];
        rr_rid  = '{1, 0, 1, 5, 0, 1, 1, 0, 0};
        rr_last = '{0, 0, 0, 1, 0, 0, 1, 0, 1};
        rr_exp  = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        do_reset();
        rd_req = 2'b11; rd_type = 6'b100_100; rd_addr = {32'h0000_3000, 32'h0000_2000};
        @(negedge aclk);
        vectors++; if (rd_rdy !== 2'b01) begin miscompares++; $display("FAIL rr_first got=%b exp=01", rd_rdy); end
        @(posedge aclk); #1;
        rd_req = 2'b10; arready = 1'b1;
        @(negedge aclk);
        vectors++; if (arid !== 4'd0 || araddr !== 32'h2000 || rd_rdy !== 2'b00) begin miscompares++; $display("FAIL rr_ar0 got id=%h a=%h rdy=%b exp 0/2000/00", arid, araddr, rd_rdy); end
        @(posedge aclk); #1;
        arready = 1'b0;
        @(negedge aclk);
        vectors++; if (rd_rdy !== 2'b10) begin miscompares++; $display("FAIL rr_second got=%b exp=10", rd_rdy); end
        @(posedge aclk); #1;
        rd_req = 2'b00; arready = 1'b1;
        @(negedge aclk);
        vectors++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h3000) begin miscompares++; $display("FAIL rr_ar1 got v=%b id=%h a=%h exp 1/1/3000", arvalid, arid, araddr); end
        @(posedge aclk); #1;
        arready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            rvalid = 1'b1; rid = 4'(rr_rid[k]); rdata = 32'hC000_0000 + 32'(k); rlast = rr_last[k];
            @(negedge aclk);
            vectors++; if (ret_valid !== rr_exp[k] || ret_data !== 32'hC000_0000 + 32'(k) || ret_last !== rr_last[k])
                begin miscompares++; $display("FAIL rr_beat%0d got v=%b d=%h l=%b exp v=%b", k, ret_valid, ret_data, ret_last, rr_exp[k]); end
            @(posedge aclk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_hazard();
        do_reset();
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_1000;
        wr_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        rd_req = 2'b10; rd_type = 6'b100_000; rd_addr = {32'h0000_1008, 32'h0};
        @(negedge aclk);
        vectors++; if (wr_rdy !== 1'b1 || rd_rdy !== 2'b00) begin miscompares++; $display("FAIL hz_same_cycle got wr_rdy=%b rd_rdy=%b exp 1/00", wr_rdy, rd_rdy); end
        @(posedge aclk); #1;
        wr_req = 1'b0; awready = 1'b1; wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            vectors++; if (wdata !== 32'hD000_0000 + 32'(k) || wlast !== (k == 3) || awvalid !== (k == 0) || rd_rdy !== 2'b00)
                begin miscompares++; $display("FAIL hz_wbeat%0d got d=%h l=%b awv=%b rdy=%b", k, wdata, wlast, awvalid, rd_rdy); end
            if (k == 0) begin
                vectors++; if (awaddr !== 32'h1000 || awlen !== 4'd3 || awid !== 4'd1 || wstrb !== 4'hf)
                    begin miscompares++; $display("FAIL hz_aw got a=%h len=%0d id=%0d strb=%h exp 1000/3/1/f", awaddr, awlen, awid, wstrb); end
            end
            @(posedge aclk);
        end
        #1; awready = 1'b0; wready = 1'b0;
        @(negedge aclk);
        vectors++; if (bready !== 1'b1 || wvalid !== 1'b0 || rd_rdy !== 2'b00) begin miscompares++; $display("FAIL hz_resp got bready=%b wvalid=%b rdy=%b exp 1/0/00", bready, wvalid, rd_rdy); end
        @(posedge aclk); #1;
        bvalid = 1'b1;
        @(negedge aclk);
        vectors++; if (rd_rdy !== 2'b00 || wr_rdy !== 1'b0) begin miscompares++; $display("FAIL hz_bvalid got rd_rdy=%b wr_rdy=%b exp 00/0", rd_rdy, wr_rdy); end
        @(posedge aclk); #1;
        bvalid = 1'b0;
        @(negedge aclk);
        vectors++; if (rd_rdy !== 2'b10 || wr_rdy !== 1'b1) begin miscompares++; $display("FAIL hz_release got rd_rdy=%b wr_rdy=%b exp 10/1", rd_rdy, wr_rdy); end
        @(posedge aclk); #1;
        rd_req = 2'b00; arready = 1'b1;
        @(negedge aclk);
        vectors++; if (araddr !== 32'h1008 || arid !== 4'd1) begin miscompares++; $display("FAIL hz_ar got a=%h id=%0d exp 1008/1", araddr, arid); end
        @(posedge aclk); #1;
        arready = 1'b0;
    endtask

    task automatic test_uncached_write();
        do_reset();
        wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'hBFAF_0001; wr_wstrb = 4'b0010;
        wr_data = '0; wr_data[31:0] = 32'h0000_AB00;
        @(posedge aclk); #1;
        wr_req = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge aclk);
        vectors++; if (awlen !== 4'd0 || awsize !== 3'd0 || awaddr !== 32'hBFAF_0001) begin miscompares++; $display("FAIL uc_aw got len=%0d size=%0d a=%h exp 0/0/bfaf0001", awlen, awsize, awaddr); end
        vectors++; if (wstrb !== 4'b0010 || wlast !== 1'b1 || wdata !== 32'h0000_AB00 || wvalid !== 1'b1) begin miscompares++; $display("FAIL uc_w got strb=%b l=%b d=%h v=%b", wstrb, wlast, wdata, wvalid); end
        @(posedge aclk); #1;
        awready = 1'b0; wready = 1'b0;
        @(negedge aclk);
        vectors++; if (bready !== 1'b1 || wvalid !== 1'b0) begin miscompares++; $display("FAIL uc_resp got bready=%b wvalid=%b exp 1/0", bready, wvalid); end
        @(posedge aclk); #1;
        bvalid = 1'b1;
        @(negedge aclk);
        vectors++; if (wr_rdy !== 1'b0) begin miscompares++; $display("FAIL uc_b2b_gap got=%b exp=0", wr_rdy); end
        @(posedge aclk); #1;
        bvalid = 1'b0;
        @(negedge aclk);
        vectors++; if (wr_rdy !== 1'b1 || bready !== 1'b0) begin miscompares++; $display("FAIL uc_idle got wr_rdy=%b bready=%b exp 1/0", wr_rdy, bready); end
    endtask

    task automatic test_aw_late();
        do_reset();
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_4000;
        wr_data = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
        @(posedge aclk); #1;
        wr_req = 1'b0; wready = 1'b1; awready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            vectors++; if (wdata !== 32'hE000_0000 + 32'(k) || wvalid !== 1'b1 || wlast !== (k == 3))
                begin miscompares++; $display("FAIL late_wbeat%0d got d=%h v=%b l=%b", k, wdata, wvalid, wlast); end
            @(posedge aclk);
        end
        #1; wready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge aclk);
            vectors++; if (awvalid !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0)
                begin miscompares++; $display("FAIL late_wait%0d got awv=%b wv=%b bready=%b exp 1/0/0", j, awvalid, wvalid, bready); end
            @(posedge aclk);
        end
        #1; awready = 1'b1;
        @(posedge aclk); #1;
        awready = 1'b0;
        @(negedge aclk);
        vectors++; if (bready !== 1'b1 || awvalid !== 1'b0) begin miscompares++; $display("FAIL late_resp got bready=%b awv=%b exp 1/0", bready, awvalid); end
        @(posedge aclk); #1;
        bvalid = 1'b1;
        @(posedge aclk); #1;
        bvalid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rd_req = 2'b01; rd_type = 6'b000_100; rd_addr = {32'h0, 32'h0000_5000};
        @(posedge aclk); #1;
        rd_req = 2'b00; arready = 1'b1;
        @(posedge aclk); #1;
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hF000_0000; rlast = 1'b0;
        @(negedge aclk);
        vectors++; if (ret_valid !== 2'b01) begin miscompares++; $display("FAIL rst_beat0 got=%b exp=01", ret_valid); end
        @(posedge aclk); #1;
        rdata = 32'hF000_0001;
        @(negedge aclk);
        vectors++; if (ret_valid !== 2'b01) begin miscompares++; $display("FAIL rst_beat1 got=%b exp=01", ret_valid); end
        @(posedge aclk); #1;
        areset = 1'b1; rdata = 32'hF000_0002;
        @(negedge aclk);
        vectors++; if (ret_valid !== 2'b00 || rready !== 1'b0 || arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_during got v=%b rready=%b arv=%b exp 00/0/0", ret_valid, rready, arvalid); end
        @(posedge aclk); #1;
        areset = 1'b0; rdata = 32'hF000_0003; rlast = 1'b1;
        @(negedge aclk);
        vectors++; if (ret_valid !== 2'b00 || rready !== 1'b1) begin miscompares++; $display("FAIL rst_late_beat got v=%b rready=%b exp 00/1", ret_valid, rready); end
        vectors++; if (araddr !== 32'h0 || arlen !== 4'h0 || arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_fields got a=%h len=%h arv=%b exp 0/0/0", araddr, arlen, arvalid); end
        @(posedge aclk); #1;
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_line_read();
        test_round_robin();
        test_hazard();
        test_uncached_write();
        test_aw_late();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_cache_bridge.md
# axi_cache_bridge

Parametrised bridge between the CPU's cache refill/writeback ports and a single AXI3 master interface. Arbitrates NRD read ports round-robin, keeps up to one outstanding burst read per port (ID = port index), streams R beats to the owning port with no buffering, and issues one line or uncached write at a time from an internal line buffer. Reads that hit a line with a write in flight are held until the write response returns. Sits between the I/D caches and the AXI crossbar at the CPU top level.

## Interface
- NRD, 2: number of read ports (port 0 = icache, 1 = dcache, 2.. = extra masters); 1..4
- LINE_WORDS, 4: 32-bit words per cache line; power of two, 2..16
- ID_W, 4: AXI ID width; NRD <= 2**ID_W
- aclk  in  1  clock; one clock domain
- areset  in  1  reset; synchronous, active-high
- rd_req / rd_rdy  in/out  NRD  per-port read request / accept (handshake when both 1)
- rd_type  in  3*NRD  per-port: 000 byte, 001 half, 010 word, 100 line
- rd_addr  in  32*NRD  per-port byte address
- ret_valid  out  NRD  per-port return beat valid
- ret_last  out  1  last beat of returning transaction
- ret_data  out  32  beat data (shared by all ports)
- wr_req / wr_rdy  in/out  1  write request / accept
- wr_type  in  3  encoding as rd_type
- wr_addr  in  32  byte address
- wr_wstrb  in  4  byte strobe (uncached only)
- wr_data  in  32*LINE_WORDS  line data; word 0 only for uncached
- AXI3 AR (arid..arvalid/arready), R (rid, rdata, rresp, rlast, rvalid/rready), AW, W (wid, wdata, wstrb, wlast), B (bid, bresp, bvalid/bready): standard AXI3 widths, IDs ID_W

## Operation
- Read accept: AR FSM AR_IDLE/AR_VALID. In AR_IDLE, eligible[i] = rd_req[i] & ~busy[i] & ~hazard[i]; rr_arbiter grants one, rd_rdy[grant]=1 that cycle (combinational); all other rd_rdy = 0. In AR_VALID all rd_rdy = 0.
- On accept: latch arid=grant, araddr, arlen = line ? LINE_WORDS-1 : 0, arsize = line ? 2 : type[1:0]; set busy[grant]; RR pointer moves to grant+1 (mod NRD); go AR_VALID.
- AR_VALID: arvalid=1, fields stable; on arready -> AR_IDLE.
- R: rready=1 whenever not in reset. ret_valid[i] = rvalid & rid==i & busy[i]; ret_data=rdata, ret_last=rlast. rlast beat with rid==i clears busy[i]. Unmatched rid beats are consumed and dropped. rresp, bresp ignored.
- Write FSM W_IDLE/W_SEND/W_RESP. wr_rdy = 1 only in W_IDLE. Accept latches addr, type, wstrb (line: 4'hf), full wr_data into buffer; beat counter reset to 0; -> W_SEND.
- W_SEND: awvalid until AW handshake (then low); wvalid until last W handshake; wdata = buf[cnt], wlast = (cnt == awlen); cnt increments per W handshake. AW and W are independent; both done -> W_RESP. awid = wid = NRD-1 (data port), awburst = arburst = INCR (01), lock/cache/prot = 0.
- W_RESP: bready=1; bvalid -> W_IDLE.
- Hazard: hazard[i] = rd line address (addr[31:log2(4*LINE_WORDS)]) equals latched write line address while write FSM not W_IDLE, or equals wr_addr line when wr_req & wr_rdy same cycle.

## Timing
- Reset: both FSMs idle, busy=0, RR pointer=0, cnt=0; arvalid, awvalid, wvalid, bready, rready, ret_valid, rd_rdy, wr_rdy = 0 during reset; AR/AW field registers = 0 except arburst/awburst=01.
- Reset mid-transaction abandons it; late R beats find busy=0 and produce no ret_valid.
- Read latency: accept cycle T, arvalid from T+1; ret_valid same cycle as rvalid.
- Simultaneous R rlast for port i and new request from i: request not eligible that cycle (busy still set); eligible next cycle.
- Write back-to-back: min 1 idle cycle between bvalid and next wr_rdy=1 (W_IDLE entered next cycle).
- Width: cnt is log2(LINE_WORDS) bits, never wraps within a burst.

## Structure
- Package axi_bridge_pkg: rd_type encodings, AXI burst/size constants, FSM state encodings, LINE_OFF_W = log2(4*LINE_WORDS).
- Sub-module rr_arbiter #(N): request vector, pointer -> one-hot grant.

## Test plan
- Port0 line read 0x1C000000, arready immediate, 4 beats -> arlen=3, arsize=2, ret_valid[0] x4, ret_last on 4th, busy[0] cleared.
- Ports 0 and 1 request together twice -> grants 0 then 1 (RR), both ARs outstanding, interleaved R by rid routed correctly.
- Line write 0x00001000 then port1 read 0x00001008 -> read held (rd_rdy[1]=0) until bvalid, accepted cycle after W_IDLE.
- Uncached byte write wstrb=0010 at 0xBFAF0001 -> awlen=0, awsize=0, single beat wlast=1, wstrb=0010.
- AW ready 3 cycles after W completes all 4 beats -> W_RESP entered only after both; wdata order buf[0..3].
- areset during R burst -> following R beats give ret_valid=0, all outputs at reset values.
